text_ram_scheduler: RTL and testbench



---
 rtl/text_ram_scheduler_if.sv | 14 +
 rtl/text_ram_scheduler.sv | 142 ++++++++++++++
 tb/tb_text_ram_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_ram_scheduler_if.sv
// Host-side character write handshake: one (column, row, code) transfer per
// cycle when wr_valid && wr_ready.
interface text_ram_scheduler_if #(
  parameter int CHAR_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [6:0]        wr_col;
  logic [5:0]        wr_row;
  logic [CHAR_W-1:0] wr_char;

  modport master (output wr_valid, wr_col, wr_row, wr_char, input wr_ready);
  modport slave  (input wr_valid, wr_col, wr_row, wr_char, output wr_ready);
endinterface

// File: rtl/text_ram_scheduler.sv
// Character framebuffer write scheduler: buffers host writes and commits them
// (or a full-screen clear) to the character RAM only during display blanking.
module text_ram_scheduler #(
  parameter int                COLS       = 80,
  parameter int                ROWS       = 60,
  parameter int                ADDR_W     = 13,
  parameter int                CHAR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [CHAR_W-1:0] FILL_CHAR  = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_display,
  text_ram_scheduler_if.slave   wr,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  bad_coord,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_waddr,
  output logic [CHAR_W-1:0]     ram_wdata
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] CELLS   = ADDR_W'(COLS * ROWS);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_reg, state_next;
  logic                stage_valid_reg;
  logic [ADDR_W-1:0]   stage_addr_reg;
  logic [CHAR_W-1:0]   stage_char_reg;
  logic [ADDR_W-1:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [CHAR_W-1:0]   fifo_char_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic                busy_reg, bad_coord_reg;
  logic                ram_we_reg;
  logic [ADDR_W-1:0]   ram_waddr_reg;
  logic [CHAR_W-1:0]   ram_wdata_reg;

  logic                in_range, xfer, push, pop, gate;
  logic                clr_start, clr_wr, clr_done;
  logic [CNT_W-1:0]    occupancy;
  logic [ADDR_W-1:0]   wr_addr;

  assign in_range  = (32'(wr.wr_col) < COLS) && (32'(wr.wr_row) < ROWS);
  assign wr_addr   = ADDR_W'(wr.wr_row) * ADDR_W'(COLS) + ADDR_W'(wr.wr_col);
  // The address stage counts against capacity so it can always drain into the FIFO.
  assign occupancy = count_reg + CNT_W'(stage_valid_reg);
  assign wr.wr_ready = !rst && !busy_reg && (occupancy < DEPTH_C);
  assign xfer      = wr.wr_valid && wr.wr_ready;
  assign push      = stage_valid_reg;
  assign gate      = !in_display;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    clr_start  = 1'b0;
    clr_wr     = 1'b0;
    clr_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0 && gate) begin
          pop = 1'b1;
        end else if (count_reg == '0 && !stage_valid_reg && busy_reg) begin
          state_next = ST_CLEAR;
          clr_start  = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Counter reaches CELLS one cycle after the last fill write, so busy drops then.
        if (clr_cnt_reg == CELLS) begin
          state_next = ST_IDLE;
          clr_done   = 1'b1;
        end else if (gate) begin
          clr_wr = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entry storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= stage_addr_reg;
      fifo_char_mem[wr_ptr_reg] <= stage_char_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      stage_valid_reg <= 1'b0;
      stage_addr_reg  <= '0;
      stage_char_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      clr_cnt_reg     <= '0;
      busy_reg        <= 1'b0;
      bad_coord_reg   <= 1'b0;
      ram_we_reg      <= 1'b0;
      ram_waddr_reg   <= '0;
      ram_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      stage_valid_reg <= xfer && in_range;
      if (xfer) begin
        stage_addr_reg <= wr_addr;
        stage_char_reg <= wr.wr_char;
      end
      if (xfer && !in_range) bad_coord_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

      if (clr_req && !busy_reg) busy_reg <= 1'b1;
      else if (clr_done)        busy_reg <= 1'b0;

      if (clr_start)   clr_cnt_reg <= '0;
      else if (clr_wr) clr_cnt_reg <= clr_cnt_reg + 1'b1;

      ram_we_reg <= pop || clr_wr;
      if (pop) begin
        ram_waddr_reg <= fifo_addr_mem[rd_ptr_reg];
        ram_wdata_reg <= fifo_char_mem[rd_ptr_reg];
      end else if (clr_wr) begin
        ram_waddr_reg <= clr_cnt_reg;
        ram_wdata_reg <= FILL_CHAR;
      end
    end
  end

  assign busy      = busy_reg;
  assign bad_coord = bad_coord_reg;
  assign ram_we    = ram_we_reg;
  assign ram_waddr = ram_waddr_reg;
  assign ram_wdata = ram_wdata_reg;
endmodule

// File: tb/tb_text_ram_scheduler.sv
// Randomized self-checking bench for text_ram_scheduler against a queue-based
// model of the expected RAM write stream.
module tb_text_ram_scheduler;
  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_display = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy, bad_coord, ram_we;
  logic [12:0] ram_waddr;
  logic [7:0]  ram_wdata;

  text_ram_scheduler_if #(.CHAR_W(8)) wr_if ();

  text_ram_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .in_display (in_display),
    .wr         (wr_if),
    .clr_req    (clr_req),
    .busy       (busy),
    .bad_coord  (bad_coord),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic disp_at_edge = 1'b0;

  int obs_addr[$];
  int obs_data[$];
  int obs_cyc[$];
  bit obs_disp[$];
  int exp_addr[$];
  int exp_data[$];

  always @(posedge clk) begin
    cyc++;
    disp_at_edge = in_display;
  end

  always @(negedge clk) begin
    if (ram_we) begin
      obs_addr.push_back(int'(ram_waddr));
      obs_data.push_back(int'(ram_wdata));
      obs_cyc.push_back(cyc);
      obs_disp.push_back(disp_at_edge);
    end
  end

  task automatic clear_logs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_disp.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; wr_if.wr_valid = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  // Presents one write and holds it until accepted (bounded); ends on a negedge.
  task automatic send(input int col, input int row, input int ch, output int hs_cyc, output bit ok);
    ok = 1'b0; hs_cyc = -1;
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_col = 7'(col); wr_if.wr_row = 6'(row); wr_if.wr_char = 8'(ch);
    for (int t = 0; t < 300 && !ok; t++) begin
      if (wr_if.wr_ready) begin
        ok = 1'b1; hs_cyc = cyc + 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    $display("write col=%0d row=%0d char=%02h accepted=%0d edge=%0d", col, row, ch, ok, hs_cyc);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", wr_if.wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bad_coord !== 1'b0) begin errors++; $display("FAIL reset_bad got %b want 0", bad_coord); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ram_we); end
    checks++; if (ram_waddr !== 13'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", ram_waddr); end
    checks++; if (ram_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", ram_wdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", wr_if.wr_ready); end
    clear_logs();
  endtask

  task automatic test_single_write();
    int hs; bit ok;
    apply_reset();
    in_display = 1'b0;
    send(5, 2, 8'h41, hs, ok);
    repeat (5) @(negedge clk);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept got %0d want 1", ok); end
    checks++;
    if (obs_addr.size() != 1) begin
      errors++; $display("FAIL single_count got %0d want 1", obs_addr.size());
    end else begin
      checks++; if (obs_addr[0] != 165) begin errors++; $display("FAIL single_addr got %0d want 165", obs_addr[0]); end
      checks++; if (obs_data[0] != 'h41) begin errors++; $display("FAIL single_data got %0h want 41", obs_data[0]); end
      checks++; if (obs_cyc[0] != hs + 2) begin errors++; $display("FAIL single_latency got edge %0d want %0d", obs_cyc[0], hs + 2); end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0; int cols[6]; int rows[6]; int chs[6]; int bad = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cols[i] = $urandom_range(0, COLS - 1); rows[i] = $urandom_range(0, ROWS - 1); chs[i] = $urandom_range(0, 255);
    end
    in_display = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      wr_if.wr_valid = (acc < 6);
      if (acc < 6) begin
        wr_if.wr_col = 7'(cols[acc]); wr_if.wr_row = 6'(rows[acc]); wr_if.wr_char = 8'(chs[acc]);
        if (wr_if.wr_ready) begin
          exp_addr.push_back(rows[acc] * COLS + cols[acc]); exp_data.push_back(chs[acc]); acc++;
        end
      end
      @(negedge clk);
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL b2b_accepts_visible got %0d want 4", acc); end
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", wr_if.wr_ready); end
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL b2b_no_write_visible got %0d want 0", obs_addr.size()); end
    in_display = 1'b0;
    for (int t = 0; t < 40 && acc < 6; t++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_col = 7'(cols[acc]); wr_if.wr_row = 6'(rows[acc]); wr_if.wr_char = 8'(chs[acc]);
      if (wr_if.wr_ready) begin
        exp_addr.push_back(rows[acc] * COLS + cols[acc]); exp_data.push_back(chs[acc]); acc++;
      end
      @(negedge clk);
    end
    wr_if.wr_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (obs_addr.size() != 6) begin
      errors++; $display("FAIL b2b_count got %0d want 6", obs_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) bad++;
      for (int i = 0; i < 3; i++) if (obs_cyc[i + 1] != obs_cyc[i] + 1) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order got %0d bad entries want 0", bad); end
    end
  endtask

  task automatic test_bad_coord();
    int hs; bit ok;
    apply_reset();
    in_display = 1'b0;
    send(80, 0, 8'h11, hs, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bad_accept got %0d want 1", ok); end
    checks++; if (bad_coord !== 1'b1) begin errors++; $display("FAIL bad_set got %b want 1", bad_coord); end
    send(3, 59, 8'h22, hs, ok);
    send(0, 60, 8'h33, hs, ok);
    repeat (6) @(negedge clk);
    checks++; if (bad_coord !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", bad_coord); end
    checks++;
    if (obs_addr.size() != 1) begin
      errors++; $display("FAIL bad_no_write got %0d writes want 1", obs_addr.size());
    end else begin
      checks++; if (obs_addr[0] != 59 * COLS + 3) begin errors++; $display("FAIL bad_valid_addr got %0d want %0d", obs_addr[0], 59 * COLS + 3); end
    end
  endtask

  task automatic test_random();
    bit bad_exp = 1'b0; int bad = 0; int gated = 0; int col, row, ch;
    apply_reset();
    @(negedge clk);
    for (int t = 0; t < 400; t++) begin
      in_display = ($urandom_range(0, 1) == 1);
      wr_if.wr_valid = ($urandom_range(0, 3) != 0);
      col = $urandom_range(0, 99); row = $urandom_range(0, 63); ch = $urandom_range(0, 255);
      wr_if.wr_col = 7'(col); wr_if.wr_row = 6'(row); wr_if.wr_char = 8'(ch);
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        if (col < COLS && row < ROWS) begin
          exp_addr.push_back(row * COLS + col); exp_data.push_back(ch);
        end else begin
          bad_exp = 1'b1;
        end
      end
      @(negedge clk);
    end
    wr_if.wr_valid = 1'b0; in_display = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) bad++;
    foreach (obs_disp[i]) if (obs_disp[i]) gated++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_data got %0d bad entries want 0", bad); end
    checks++; if (gated != 0) begin errors++; $display("FAIL rand_gate got %0d visible writes want 0", gated); end
    checks++; if (bad_coord !== bad_exp) begin errors++; $display("FAIL rand_bad_coord got %b want %b", bad_coord, bad_exp); end
  endtask

  task automatic test_clear();
    int hs; bit ok; int fall = -1; int ready_viol = 0; int bad = 0;
    apply_reset();
    in_display = 1'b1;
    send(7, 1, 8'h55, hs, ok);
    exp_addr.push_back(1 * COLS + 7); exp_data.push_back('h55);
    send(79, 59, 8'h66, hs, ok);
    exp_addr.push_back(59 * COLS + 79); exp_data.push_back('h66);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %b want 1", busy); end
    checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", wr_if.wr_ready); end
    in_display = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      clr_req = (t == 100);
      if (!busy) begin fall = cyc; break; end
      if (wr_if.wr_ready) ready_viol++;
      @(negedge clk);
    end
    clr_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (fall < 0) begin errors++; $display("FAIL clr_timeout got busy=%b want 0", busy); end
    checks++; if (ready_viol != 0) begin errors++; $display("FAIL clr_ready_busy got %0d cycles want 0", ready_viol); end
    checks++;
    if (obs_addr.size() != CELLS + 2) begin
      errors++; $display("FAIL clr_count got %0d want %0d", obs_addr.size(), CELLS + 2);
    end else begin
      for (int i = 0; i < 2; i++) if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) bad++;
      for (int i = 0; i < CELLS; i++) if (obs_addr[i + 2] != i || obs_data[i + 2] != 'h20) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clr_content got %0d bad entries want 0", bad); end
      checks++; if (obs_cyc[CELLS + 1] != fall - 1) begin errors++; $display("FAIL clr_busy_fall got edge %0d want %0d", fall, obs_cyc[CELLS + 1] + 1); end
    end
  endtask

  task automatic test_clear_toggle();
    bit done = 1'b0; int bad = 0; int gated = 0;
    apply_reset();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int t = 0; t < 40000; t++) begin
      in_display = ((t % 20) < 12) && (((t / 20) % 50) < 45);
      if (!busy) begin done = 1'b1; break; end
      @(negedge clk);
    end
    in_display = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!done) begin errors++; $display("FAIL tog_timeout got busy=%b want 0", busy); end
    checks++; if (obs_addr.size() != CELLS) begin errors++; $display("FAIL tog_count got %0d want %0d", obs_addr.size(), CELLS); end
    for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i || obs_data[i] != 'h20) bad++;
    foreach (obs_disp[i]) if (obs_disp[i]) gated++;
    checks++; if (bad != 0) begin errors++; $display("FAIL tog_content got %0d bad entries want 0", bad); end
    checks++; if (gated != 0) begin errors++; $display("FAIL tog_gate got %0d visible writes want 0", gated); end
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 1'b0; int hs; bit ok;
    apply_reset();
    in_display = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (ram_we && ram_waddr == 13'd1000) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reach got %0d want 1", hit); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", ram_we); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", wr_if.wr_ready); end
    clear_logs();
    repeat (6) @(negedge clk);
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL mid_abandon got %0d writes want 0", obs_addr.size()); end
    send(10, 3, 8'h5A, hs, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (obs_addr.size() != 1) begin
      errors++; $display("FAIL mid_new_count got %0d want 1", obs_addr.size());
    end else begin
      checks++; if (obs_addr[0] != 250 || obs_data[0] != 'h5A) begin errors++; $display("FAIL mid_new_write got %0d/%0h want 250/5a", obs_addr[0], obs_data[0]); end
    end
  endtask

  initial begin
    wr_if.wr_valid = 1'b0; wr_if.wr_col = '0; wr_if.wr_row = '0; wr_if.wr_char = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_coord();
    test_random();
    test_clear();
    test_clear_toggle();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
